// File: rtl/ysyx_22040759_define.sv
// Shared encodings for the memory-port arbiter: FSM states, owner tags and
// the fixed access size used for instruction fetches.
package ysyx_22040759_define;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [2:0] IF_SIZE = 3'b010;

endpackage

// File: rtl/ysyx_22040759_arb_pick.sv
// Two-way priority pick: LS normally wins a tie, but the IF requester takes
// the tie when it was passed over last time (if_turn).
module ysyx_22040759_arb_pick
  import ysyx_22040759_define::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic if_turn,
  output logic pick_valid,
  output logic pick_owner
);

  always_comb begin
    pick_valid = if_req | ls_req;
    pick_owner = OWN_IF;
    if (ls_req && !(if_req && if_turn)) begin
      pick_owner = OWN_LS;
    end
  end

endmodule

// File: rtl/ysyx_22040759_mem_arb.sv
// Shares one downstream memory port between instruction fetch and load/store.
// One transaction at a time: arbitrate, latch, req/gnt handshake, route response.
module ysyx_22040759_mem_arb
  import ysyx_22040759_define::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_wen,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [2:0]          ls_size,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2:0]          mem_size,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [1:0] state_reg;
  logic       owner_reg;
  logic       if_turn_reg;
  logic       pick_valid;
  logic       pick_owner;
  logic       resp_done;

  ysyx_22040759_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .if_turn    (if_turn_reg),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // A response can complete in the grant cycle itself; responses seen in IDLE are dropped.
  assign resp_done = mem_rvalid &&
                     (((state_reg == ARB_REQ) && mem_gnt) || (state_reg == ARB_RESP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      owner_reg   <= OWN_IF;
      if_turn_reg <= 1'b0;
      mem_req     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_size    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      ls_gnt      <= 1'b0;
      ls_rvalid   <= 1'b0;
      ls_rdata    <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;

      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_reg <= ARB_REQ;
            owner_reg <= pick_owner;
            mem_req   <= 1'b1;
            if (pick_owner == OWN_LS) begin
              ls_gnt    <= 1'b1;
              mem_wen   <= ls_wen;
              mem_addr  <= ls_addr;
              mem_size  <= ls_size;
              mem_wdata <= ls_wdata;
              mem_wstrb <= ls_wstrb;
              // IF was passed over, so it wins the next tie.
              if (if_req) begin
                if_turn_reg <= 1'b1;
              end
            end else begin
              if_gnt      <= 1'b1;
              mem_wen     <= 1'b0;
              mem_addr    <= if_addr;
              mem_size    <= IF_SIZE;
              mem_wdata   <= '0;
              mem_wstrb   <= '0;
              if_turn_reg <= 1'b0;
            end
          end
        end
        ARB_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            state_reg <= mem_rvalid ? ARB_IDLE : ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (mem_rvalid) begin
            state_reg <= ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase

      if (resp_done) begin
        if (owner_reg == OWN_LS) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule
